change_dispenser: RTL and testbench
===================================

# change_dispenser

Vending-machine change/refund dispenser. It executes the refund and release commands issued by the control unit. On a command it latches the amount owed and pays it out one coin at a time through a 4-phase request/acknowledge handshake with the coin hopper, using greedy denomination selection. It sits between the control unit and datapath on one side and the hopper driver on the other.

## Interface
Parameters:
- AMT_W, 8, width of money values; units are 10 sen.
- TIMEOUT, 255, hopper ack watchdog limit in cycles; used only with HOPPER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all registers update on the falling edge, matching the control unit.
- rst  in  1  asynchronous, active-high reset.
- refund  in  1  control unit refund command; level, one or more cycles.
- release  in  1  control unit release command (ldSelect); level.
- payment  in  AMT_W  accumulated payment from the datapath.
- price  in  AMT_W  selected item price from the datapath.
- hopper_ack  in  1  hopper acknowledge.
- coin_req  out  3  one-hot coin request: [2] 50 sen, [1] 20 sen, [0] 10 sen.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when payout completes.
- underflow  out  1  one-cycle pulse when release is captured with payment < price.
- remaining  out  AMT_W  amount still owed.
- fault  out  1  one-cycle pulse on watchdog abort; constant 0 without HOPPER_TIMEOUT_EN.

## Operation
- FSM states: IDLE, REQ, ACKLOW, DONE.
- IDLE:
  - refund sampled high: remaining <= payment.
  - else release sampled high: remaining <= payment − price, or 0 with an underflow pulse if payment < price.
  - refund and release both high: refund wins.
  - Captured amount 0: go to DONE. Nonzero: go to REQ.
- REQ: coin_req is the greedy choice from remaining.
  - remaining ≥ 5: 3'b100.
  - else remaining ≥ 2: 3'b010.
  - else: 3'b001.
  - coin_req is held stable until hopper_ack is sampled high. Then remaining <= remaining − value and go to ACKLOW.
- ACKLOW: coin_req = 0. When hopper_ack is sampled low: remaining = 0 goes to DONE, else back to REQ.
- DONE: done = 1 for one cycle, then IDLE.
- Commands arriving while busy are ignored and not queued. A command still held when IDLE is re-entered is captured again. The control unit holds refund/release for one cycle only.
- Subtraction never underflows: the greedy choice is always ≤ remaining.

## Timing
- Reset values: state IDLE, coin_req 0, busy 0, done 0, underflow 0, fault 0, remaining 0.
- Reset mid-payout: coin_req drops asynchronously and the owed amount is discarded.
- Command sampled at falling edge N: busy and remaining valid after edge N; coin_req high after edge N.
- Per coin with immediate hopper response: 2 cycles (REQ + ACKLOW). Payout of k coins completes with done in cycle 2k+1 after capture.
- Zero amount: done in the cycle after capture, no coin_req.
- Outputs are Moore, decoded from registered state and remaining only.

## Configuration
- Macro HOPPER_TIMEOUT_EN.
- Defined:
  - A counter of ceil(log2(TIMEOUT+1)) bits runs in REQ and ACKLOW and clears on each state change.
  - On reaching TIMEOUT: coin_req = 0, fault pulses for one cycle, state goes to IDLE with no done pulse.
  - remaining retains the undispensed amount until the next capture.
- Undefined: no counter; the FSM waits indefinitely for hopper_ack; fault is tied to 0.

## Test plan
- refund=1, payment=8, hopper acks after 1 cycle: coin_req sequence 100, 010, 001, remaining 8→3→1→0, then one done pulse. busy is high from capture through DONE.
- release=1, payment=10, price=6, ack after 3 cycles: coin_req 010 then 010, each held until ack. remaining 4→2→0, then done.
- release=1, payment=3, price=5: underflow pulse, remaining=0, done the next cycle, no coin_req.
- refund and release both high, payment=4, price=1: refund wins, two 20-sen coins. A second refund pulse during the payout is ignored.
- Assert rst while coin_req=100 is waiting for ack: coin_req, busy and remaining go to 0 immediately; state is IDLE after release of rst.
- With HOPPER_TIMEOUT_EN and TIMEOUT=4, hopper_ack stuck low, refund with payment=1: coin_req=001 for 4 cycles, then a fault pulse, return to IDLE, remaining=1, no done.

Source files
------------

// File: rtl/change_dispenser.sv
// Change/refund dispenser: latches the amount owed on a refund or release command and
// pays it out greedily (50/20/10 sen) via a 4-phase handshake. Optional macro HOPPER_TIMEOUT_EN.
module change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refund,
    input  logic             release_cmd,
    input  logic [AMT_W-1:0] payment,
    input  logic [AMT_W-1:0] price,
    input  logic             hopper_ack,
    output logic [2:0]       coin_req,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [AMT_W-1:0] remaining,
    output logic             fault
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACKLOW = 2'd2, DONE = 2'd3} state_t;

    state_t           state_r, state_s;
    logic [AMT_W-1:0] remaining_r, remaining_s;
    logic             underflow_r, underflow_s;
    logic             fault_r, fault_s;
    logic             timeout_s;

    function automatic logic [2:0] greedy_coin(input logic [AMT_W-1:0] amt);
        logic [2:0] c;
        if (amt >= AMT_W'(5)) begin
            c = 3'b100;
        end else if (amt >= AMT_W'(2)) begin
            c = 3'b010;
        end else begin
            c = 3'b001;
        end
        return c;
    endfunction

    function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] c);
        logic [AMT_W-1:0] v;
        case (c)
            3'b100:  v = AMT_W'(5);
            3'b010:  v = AMT_W'(2);
            default: v = AMT_W'(1);
        endcase
        return v;
    endfunction

`ifdef HOPPER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_r;

    assign timeout_s = (cnt_r == TO_LAST);

    // Watchdog: counts cycles spent in one handshake state, cleared on every transition.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == REQ || state_r == ACKLOW) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
    assign timeout_s        = 1'b0;
`endif

    // Next-state and datapath: capture, per-coin decrement, completion and abort.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        underflow_s = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (refund) begin
                    remaining_s = payment;
                    state_s     = (payment == {AMT_W{1'b0}}) ? DONE : REQ;
                end else if (release_cmd) begin
                    if (payment < price) begin
                        remaining_s = {AMT_W{1'b0}};
                        underflow_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        remaining_s = payment - price;
                        state_s     = (payment == price) ? DONE : REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (hopper_ack) begin
                    remaining_s = remaining_r - coin_value(greedy_coin(remaining_r));
                    state_s     = ACKLOW;
                end else if (timeout_s) begin
                    fault_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            ACKLOW: begin
                if (!hopper_ack) begin
                    state_s = (remaining_r == {AMT_W{1'b0}}) ? DONE : REQ;
                end else if (timeout_s) begin
                    fault_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = ACKLOW;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and amount registers, clocked on the falling edge like the control unit.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= {AMT_W{1'b0}};
            underflow_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            underflow_r <= underflow_s;
            fault_r     <= fault_s;
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        if (state_r == REQ) begin
            coin_req = greedy_coin(remaining_r);
        end else begin
            coin_req = 3'b000;
        end
    end

    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);
    assign underflow = underflow_r;
    assign remaining = remaining_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; timeout scenario runs when HOPPER_TIMEOUT_EN is defined.
module tb_change_dispenser;

    localparam int AMT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             refund;
    logic             release_cmd;
    logic [AMT_W-1:0] payment;
    logic [AMT_W-1:0] price;
    logic             hopper_ack;
    logic [2:0]       coin_req;
    logic             busy;
    logic             done;
    logic             underflow;
    logic [AMT_W-1:0] remaining;
    logic             fault;

    int vectors     = 0;
    int miscompares = 0;

    change_dispenser #(.AMT_W(AMT_W), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .refund     (refund),
        .release_cmd(release_cmd),
        .payment    (payment),
        .price      (price),
        .hopper_ack (hopper_ack),
        .coin_req   (coin_req),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow),
        .remaining  (remaining),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full output snapshot: coin_req, busy, done, underflow, remaining, fault.
    task automatic chk_all(input string tag, input logic [2:0] c, input logic b, input logic d,
                           input logic u, input logic [AMT_W-1:0] r, input logic f);
        chk({tag, ".coin_req"}, 32'(coin_req), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".underflow"}, 32'(underflow), 32'(u));
        chk({tag, ".remaining"}, 32'(remaining), 32'(r));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    // Advance past the next active (falling) edge and let outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One coin: hopper waits 'dly' cycles before acking, then releases ack immediately.
    task automatic pay_coin(input string tag, input logic [2:0] c,
                            input logic [AMT_W-1:0] r_before, input logic [AMT_W-1:0] r_after,
                            input int dly);
        for (int i = 0; i < dly; i++) begin
            chk_all({tag, ".wait"}, c, 1'b1, 1'b0, 1'b0, r_before, 1'b0);
            step();
        end
        chk_all({tag, ".req"}, c, 1'b1, 1'b0, 1'b0, r_before, 1'b0);
        hopper_ack = 1'b1;
        step();
        chk_all({tag, ".acklow"}, 3'b000, 1'b1, 1'b0, 1'b0, r_after, 1'b0);
        hopper_ack = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; refund = 1'b0; release_cmd = 1'b0;
        payment = 8'd0; price = 8'd0; hopper_ack = 1'b0;
        #2;
        chk_all("reset", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        rst = 1'b0;
        step();
        chk_all("idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // refund 80 sen: 50 + 20 + 10, immediate hopper
        refund = 1'b1; payment = 8'd8;
        step();
        refund = 1'b0;
        pay_coin("t1c1", 3'b100, 8'd8, 8'd3, 0);
        pay_coin("t1c2", 3'b010, 8'd3, 8'd1, 0);
        pay_coin("t1c3", 3'b001, 8'd1, 8'd0, 0);
        chk_all("t1done", 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        chk_all("t1idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // release 100-60 = 40 sen, slow hopper (ack after 3 cycles)
        release_cmd = 1'b1; payment = 8'd10; price = 8'd6;
        step();
        release_cmd = 1'b0;
        pay_coin("t2c1", 3'b010, 8'd4, 8'd2, 2);
        pay_coin("t2c2", 3'b010, 8'd2, 8'd0, 2);
        chk_all("t2done", 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        chk_all("t2idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // release with payment < price: underflow, no coins
        release_cmd = 1'b1; payment = 8'd3; price = 8'd5;
        step();
        release_cmd = 1'b0;
        chk_all("t3uf", 3'b000, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0);
        step();
        chk_all("t3idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // exact payment: zero change, done next cycle
        release_cmd = 1'b1; payment = 8'd7; price = 8'd7;
        step();
        release_cmd = 1'b0;
        chk_all("t3zero", 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        step();

        // both commands: refund wins (4, not 3); mid-payout refund ignored
        refund = 1'b1; release_cmd = 1'b1; payment = 8'd4; price = 8'd1;
        step();
        refund = 1'b0; release_cmd = 1'b0;
        pay_coin("t4c1", 3'b010, 8'd4, 8'd2, 0);
        chk_all("t4req2", 3'b010, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
        refund = 1'b1; payment = 8'd7; hopper_ack = 1'b1;
        step();
        refund = 1'b0;
        chk_all("t4ign", 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        hopper_ack = 1'b0;
        step();
        chk_all("t4done", 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        chk_all("t4idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // asynchronous reset while waiting for ack on a 50-sen coin
        refund = 1'b1; payment = 8'd5;
        step();
        refund = 1'b0;
        chk_all("t5req", 3'b100, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_all("t5rst", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        rst = 1'b0;
        step();
        chk_all("t5idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

`ifdef HOPPER_TIMEOUT_EN
        // stuck hopper: 4 REQ cycles, then fault, IDLE, owed amount retained
        refund = 1'b1; payment = 8'd1;
        step();
        refund = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_all("t6req", 3'b001, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
            step();
        end
        chk_all("t6fault", 3'b000, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
        step();
        chk_all("t6idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
`else
        // stuck hopper without watchdog: request stays up, no fault
        refund = 1'b1; payment = 8'd1;
        step();
        refund = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all("t6wait", 3'b001, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
